register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/gb_cpu_pkg.sv | 13 +
 rtl/stack_pointer.sv | 18 +
 rtl/register_file.sv | 71 +++++++
 3 files changed

// File: rtl/gb_cpu_pkg.sv
// gb_cpu_pkg: register pair indices and stack pointer opcodes shared by the register file.
package gb_cpu_pkg;
  localparam logic [1:0] BC = 2'd0;
  localparam logic [1:0] DE = 2'd1;
  localparam logic [1:0] HL = 2'd2;
  localparam logic [1:0] AF = 2'd3;
  typedef enum logic [1:0] {
    SP_HOLD     = 2'b00,
    SP_STEP     = 2'b01,
    SP_LOAD     = 2'b10,
    SP_HOLD_ALT = 2'b11
  } spOp_t;
endpackage

// File: rtl/stack_pointer.sv
// stack_pointer: 16-bit stack pointer with load, +/-1 step and hold.
module stack_pointer
  import gb_cpu_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = 16'hFFFE
) (
  input  logic        clk,
  input  logic        reset,
  input  spOp_t       op,
  input  logic        dir,
  input  logic [15:0] loadVal,
  output logic [15:0] sp
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) sp <= RESET_VAL;
    else sp <= op == SP_LOAD ? loadVal :
               op == SP_STEP ? (dir ? sp - 16'd1 : sp + 16'd1) : sp;
endmodule

// File: rtl/register_file.sv
// register_file: paired register file with pair step and stack pointer.
// Define REGISTER_FILE_BYPASS_EN to let reads return same-cycle write/step results.
module register_file
  import gb_cpu_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          NUM_REGS   = 8,
  parameter logic [15:0] SP_RESET   = 16'hFFFE,
  localparam int         AW         = $clog2(NUM_REGS),
  localparam int         PW         = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wrEn,
  input  logic                  wrPair,
  input  logic [AW-1:0]         wrNum,
  input  logic [PW-1:0]         wrData,
  input  logic [AW-1:0]         rdNumA,
  input  logic [AW-1:0]         rdNumB,
  output logic [DATA_WIDTH-1:0] rdDataA,
  output logic [DATA_WIDTH-1:0] rdDataB,
  output logic [PW-1:0]         rdPairA,
  input  logic                  pairStep,
  input  logic                  pairDir,
  input  logic [1:0]            spOp,
  input  logic [15:0]           spIn,
  output logic [15:0]           stackPointer
);
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] nxt  [NUM_REGS];
  logic [DATA_WIDTH-1:0] view [NUM_REGS];
  logic [PW-1:0] pairVal, stepped;
  assign pairVal = {regs[{wrNum[AW-1:1], 1'b0}], regs[{wrNum[AW-1:1], 1'b1}]};
  assign stepped = pairDir ? pairVal - PW'(1) : pairVal + PW'(1);
  // Later assignments win: a write overrides the step only on the halves it touches.
  always_comb
    for (int i = 0; i < NUM_REGS; i++) begin
      nxt[i] = regs[i];
      if (pairStep && AW'(i >> 1) == (wrNum >> 1))
        nxt[i] = i[0] ? stepped[DATA_WIDTH-1:0] : stepped[PW-1:DATA_WIDTH];
      if (wrEn && wrPair && AW'(i >> 1) == (wrNum >> 1))
        nxt[i] = i[0] ? wrData[DATA_WIDTH-1:0] : wrData[PW-1:DATA_WIDTH];
      if (wrEn && !wrPair && AW'(i) == wrNum)
        nxt[i] = wrData[DATA_WIDTH-1:0];
    end
`ifdef REGISTER_FILE_BYPASS_EN
  assign view = nxt;
`else
  assign view = regs;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      regs    <= '{default: '0};
      rdDataA <= '0;
      rdDataB <= '0;
      rdPairA <= '0;
    end else begin
      regs    <= nxt;
      rdDataA <= view[rdNumA];
      rdDataB <= view[rdNumB];
      rdPairA <= {view[{rdNumA[AW-1:1], 1'b0}], view[{rdNumA[AW-1:1], 1'b1}]};
    end
  stack_pointer #(.RESET_VAL(SP_RESET)) spUnit (
    .clk    (clk),
    .reset  (reset),
    .op     (spOp_t'(spOp)),
    .dir    (pairDir),
    .loadVal(spIn),
    .sp     (stackPointer)
  );
endmodule
